uart_tx_buffer: RTL and testbench

- Transmit-side UART stage directly downstream of the core's uart_send_* interface.
- Buffers bytes offered by the core in a small FIFO and serialises them onto the board TX pin as 8N1 frames, LSB first.
- Decouples core store timing from line rate; backpressures the core only when the FIFO is full.

---
 rtl/uart_tx_buffer.sv | 170 +++++++++++++++++
 tb/tb_uart_tx_buffer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffer.sv
// Transmit-side UART stage: byte FIFO in front of an 8N1 serialiser (LSB first).
// txd and tx_busy are registered from the current state, so they trail the FSM by one clock.
module uart_tx_buffer #(
   parameter int unsigned CLK_PER_BIT = 868,
   parameter int unsigned DEPTH_LOG2  = 4
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [7:0] uart_send_data,
   input  logic       uart_send_ready,
   output logic       uart_send_valid,
   output logic       txd,
   output logic       tx_busy
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_CNT = DEPTH[DEPTH_LOG2:0];
   localparam logic [15:0] BAUD_LAST = 16'(CLK_PER_BIT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t                state_q,  state_d;
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q,  count_d;
   logic [2:0]            bit_idx_q, bit_idx_d;
   logic [15:0]           baud_q,   baud_d;
   logic [7:0]            shift_q,  shift_d;
   logic                  txd_q,    txd_d;
   logic                  busy_q,   busy_d;
   logic [7:0]            mem_q [DEPTH];

   logic full;
   logic push;
   logic pop;
   logic bit_done;

   assign full            = (count_q == FULL_CNT);
   assign push            = uart_send_ready && !full;
   assign bit_done        = (baud_q == BAUD_LAST);
   assign uart_send_valid = !full;
   assign txd             = txd_q;
   assign tx_busy         = busy_q;

   // FIFO storage needs no reset: entries are only read after being written.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= uart_send_data;
      end
   end

   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      pop       = 1'b0;

      case (state_q)
         S_IDLE: begin
            baud_d    = '0;
            bit_idx_d = '0;
            if (count_q != '0) begin
               pop     = 1'b1;
               state_d = S_START;
            end
         end
         S_START: begin
            if (bit_done) begin
               baud_d    = '0;
               bit_idx_d = '0;
               state_d   = S_DATA;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         S_DATA: begin
            if (bit_done) begin
               baud_d  = '0;
               shift_d = {1'b1, shift_q[7:1]};
               if (bit_idx_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         S_STOP: begin
            if (bit_done) begin
               baud_d = '0;
               // Chain straight into the next start bit when more bytes are waiting.
               if (count_q != '0) begin
                  pop     = 1'b1;
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (pop) begin
         shift_d = mem_q[rd_ptr_q];
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      txd_d = 1'b1;
      case (state_q)
         S_START: txd_d = 1'b0;
         S_DATA:  txd_d = shift_q[0];
         default: txd_d = 1'b1;
      endcase
      busy_d = (state_q != S_IDLE) || (count_q != '0);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= S_IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         bit_idx_q <= '0;
         baud_q    <= '0;
         shift_q   <= '1;
         txd_q     <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         bit_idx_q <= bit_idx_d;
         baud_q    <= baud_d;
         shift_q   <= shift_d;
         txd_q     <= txd_d;
         busy_q    <= busy_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Bench for uart_tx_buffer: directed pushes feed expected-byte queues, a serial
// monitor per instance decodes txd frames and compares against them.
module tb_uart_tx_buffer;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rstn_a, ready_a, valid_a, txd_a, busy_a;
   logic [7:0] data_a;
   logic       rstn_b, ready_b, valid_b, txd_b, busy_b;
   logic [7:0] data_b;

   uart_tx_buffer #(.CLK_PER_BIT(4), .DEPTH_LOG2(4)) dut_a (
      .clk             (clk),
      .rstn            (rstn_a),
      .uart_send_data  (data_a),
      .uart_send_ready (ready_a),
      .uart_send_valid (valid_a),
      .txd             (txd_a),
      .tx_busy         (busy_a)
   );

   uart_tx_buffer #(.CLK_PER_BIT(100), .DEPTH_LOG2(4)) dut_b (
      .clk             (clk),
      .rstn            (rstn_b),
      .uart_send_data  (data_b),
      .uart_send_ready (ready_b),
      .uart_send_valid (valid_b),
      .txd             (txd_b),
      .tx_busy         (busy_b)
   );

   int         total = 0;
   int         bad   = 0;
   logic [7:0] exp_a[$];
   logic [7:0] exp_b[$];
   int         rc_a  = 0;
   int         rc_b  = 0;

   always @(negedge rstn_a) rc_a = rc_a + 1;
   always @(negedge rstn_b) rc_b = rc_b + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic txd_of(input int w);
      return (w == 0) ? txd_a : txd_b;
   endfunction

   function automatic logic rstn_of(input int w);
      return (w == 0) ? rstn_a : rstn_b;
   endfunction

   function automatic int rc_of(input int w);
      return (w == 0) ? rc_a : rc_b;
   endfunction

   // Expand a 10-bit frame (first bit on the line in the MSB) to 4 clocks per bit.
   function automatic logic [39:0] x4(input logic [9:0] f);
      logic [39:0] r;
      for (int i = 0; i < 10; i++) begin
         for (int j = 0; j < 4; j++) begin
            r[39 - (4 * i + j)] = f[9 - i];
         end
      end
      return r;
   endfunction

   task automatic monitor(input int w, input int cpb);
      logic [7:0] b;
      logic       st, sp;
      int         rc;
      forever begin
         @(negedge clk);
         if (rstn_of(w) && txd_of(w) == 1'b0) begin
            rc = rc_of(w);
            repeat (cpb / 2) @(negedge clk);
            st = txd_of(w);
            for (int i = 0; i < 8; i++) begin
               repeat (cpb) @(negedge clk);
               b[i] = txd_of(w);
            end
            repeat (cpb) @(negedge clk);
            sp = txd_of(w);
            if (rc_of(w) == rc) begin
               check($sformatf("start_bit_%0d", w), st, 1'b0);
               check($sformatf("stop_bit_%0d", w), sp, 1'b1);
               if ((w == 0 && exp_a.size() == 0) || (w == 1 && exp_b.size() == 0)) begin
                  total++;
                  bad++;
                  $display("FAIL frame_%0d: got unexpected byte %0h want none", w, b);
               end else if (w == 0) begin
                  check("frame_a", b, exp_a.pop_front());
               end else begin
                  check("frame_b", b, exp_b.pop_front());
               end
            end
         end
      end
   endtask

   initial begin
      fork
         monitor(0, 4);
         monitor(1, 100);
      join_none
   end

   initial begin
      logic [39:0] cap40;
      logic [79:0] cap80;
      logic [49:0] cap50;
      logic [49:0] ones50;
      logic        busy_or;
      int          cur;
      int          guard;

      rstn_a = 1'b0; ready_a = 1'b0; data_a = '0;
      rstn_b = 1'b0; ready_b = 1'b0; data_b = '0;
      repeat (3) @(negedge clk);
      check("rst_txd", txd_a, 1'b1);
      check("rst_valid", valid_a, 1'b1);
      check("rst_busy", busy_a, 1'b0);
      rstn_a = 1'b1;
      rstn_b = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_txd", txd_a, 1'b1);
      check("idle_busy", busy_a, 1'b0);

      // Single byte 0xA5: exact waveform and tx_busy fall time.
      ready_a = 1'b1; data_a = 8'hA5;
      exp_a.push_back(8'hA5);
      @(negedge clk);
      ready_a = 1'b0; data_a = 8'h33;
      @(negedge clk);
      check("a5_pre_start", txd_a, 1'b1);
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         cap40[39 - k] = txd_a;
      end
      check("a5_wave", cap40, x4(10'b0101001011));
      check("a5_busy_n41", busy_a, 1'b1);
      @(negedge clk);
      check("a5_busy_n42", busy_a, 1'b0);
      repeat (10) @(negedge clk);

      // 0x00 then 0xFF back to back: two frames, no gap.
      ready_a = 1'b1; data_a = 8'h00;
      exp_a.push_back(8'h00);
      @(negedge clk);
      data_a = 8'hFF;
      exp_a.push_back(8'hFF);
      @(negedge clk);
      ready_a = 1'b0;
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         cap80[79 - k] = txd_a;
      end
      check("b2b_wave", cap80, {x4(10'b0000000001), x4(10'b0111111111)});
      repeat (10) @(negedge clk);
      check("b2b_idle_busy", busy_a, 1'b0);

      // Reset in the middle of a frame.
      ready_a = 1'b1; data_a = 8'h3C;
      @(negedge clk);
      ready_a = 1'b0;
      repeat (10) @(negedge clk);
      check("mid_busy_before", busy_a, 1'b1);
      #1 rstn_a = 1'b0;
      #1;
      check("mid_rst_txd", txd_a, 1'b1);
      check("mid_rst_valid", valid_a, 1'b1);
      check("mid_rst_busy", busy_a, 1'b0);
      @(negedge clk);
      rstn_a = 1'b1;
      busy_or = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         cap50[k] = txd_a;
         busy_or  = busy_or | busy_a;
      end
      ones50 = '1;
      check("mid_no_resume_txd", cap50, ones50);
      check("mid_no_resume_busy", busy_or, 1'b0);

      // 20 bytes, each later push landing on a STOP->START pop; pointers wrap.
      for (int i = 0; i < 4; i++) begin
         ready_a = 1'b1; data_a = 8'h40 + 8'(i);
         exp_a.push_back(8'h40 + 8'(i));
         @(negedge clk);
      end
      ready_a = 1'b0;
      cur = 3;
      for (int k = 0; k < 16; k++) begin
         repeat (41 + 40 * k - 1 - cur) @(negedge clk);
         ready_a = 1'b1; data_a = 8'h44 + 8'(k);
         exp_a.push_back(8'h44 + 8'(k));
         @(negedge clk);
         ready_a = 1'b0;
         cur = 41 + 40 * k;
      end
      repeat (801 - cur) @(negedge clk);
      check("wrap_busy_m801", busy_a, 1'b1);
      @(negedge clk);
      check("wrap_busy_m802", busy_a, 1'b0);
      check("wrap_txd_idle", txd_a, 1'b1);

      // Instance B: fill to 16, refused writes, reopen after the next pop.
      for (int i = 0; i < 17; i++) begin
         if (i == 16) check("full_valid_n15", valid_b, 1'b1);
         ready_b = 1'b1; data_b = 8'(i);
         exp_b.push_back(8'(i));
         @(negedge clk);
      end
      check("full_valid_n16", valid_b, 1'b0);
      for (int j = 0; j < 10; j++) begin
         data_b = 8'hE0 + 8'(j);
         @(negedge clk);
      end
      ready_b = 1'b0;
      check("full_valid_held", valid_b, 1'b0);
      repeat (974) @(negedge clk);
      check("full_valid_n1000", valid_b, 1'b0);
      @(negedge clk);
      check("full_valid_n1001", valid_b, 1'b1);
      ready_b = 1'b1; data_b = 8'h11;
      exp_b.push_back(8'h11);
      @(negedge clk);
      ready_b = 1'b0;

      guard = 0;
      while ((exp_a.size() != 0 || exp_b.size() != 0) && guard < 25000) begin
         @(negedge clk);
         guard++;
      end
      check("drain_left", exp_a.size() + exp_b.size(), 0);
      guard = 0;
      while (busy_b && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      check("end_busy_b", busy_b, 1'b0);
      check("end_txd_b", txd_b, 1'b1);
      check("end_valid_b", valid_b, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
